// File: rtl/mem_access_unit_if.sv
// Control-unit and memory-side signal bundle for mem_access_unit.
// slave is the unit's view; master is the control unit / RAM model view.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              rw;
  logic [1:0]        size;
  logic              sign;
  logic [DATA_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_moc;
  logic [ADDR_W-1:0] mar_out;
  logic [DATA_W-1:0] mdr_out;
  logic              mem_en;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, rw, size, sign, addr_in, wdata_in, mem_rdata, mem_moc,
    output mar_out, mdr_out, mem_en, mem_rw, mem_size, mem_wdata, busy, done, err
  );

  modport master (
    output start, rw, size, sign, addr_in, wdata_in, mem_rdata, mem_moc,
    input  mar_out, mdr_out, mem_en, mem_rw, mem_size, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR plus memory handshake FSM: byte/half/word loads and stores with
// alignment checking, load extension and a MOC completion timeout.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            CLR,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $error("mem_access_unit: ADDR_W must not exceed DATA_W");
  end
  if ((DATA_W < 16) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
    $error("mem_access_unit: DATA_W must be >= 16 and a multiple of 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] w_mar_nxt;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] w_mdr_nxt;
  logic              r_rw;
  logic              w_rw_nxt;
  logic [1:0]        r_size;
  logic [1:0]        w_size_nxt;
  logic              r_sign;
  logic              w_sign_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_illegal;
  logic              w_expired;
  logic [DATA_W-1:0] w_store_data;
  logic [DATA_W-1:0] w_load_data;
  logic              w_unused;

  // Upper address bits are deliberately discarded by the MAR.
  assign w_unused = &{1'b0, bus.addr_in};

  // Illegal size or misaligned address for the requested width.
  always_comb begin
    w_illegal = 1'b0;
    case (bus.size)
      2'b00:   w_illegal = 1'b0;
      2'b01:   w_illegal = bus.addr_in[0];
      2'b10:   w_illegal = (bus.addr_in[1:0] != 2'b00);
      default: w_illegal = 1'b1;
    endcase
  end

  // Store data with bits above the access size cleared.
  always_comb begin
    w_store_data = bus.wdata_in;
    case (bus.size)
      2'b00:   w_store_data = DATA_W'(bus.wdata_in[7:0]);
      2'b01:   w_store_data = DATA_W'(bus.wdata_in[15:0]);
      default: w_store_data = bus.wdata_in;
    endcase
  end

  // Load data extended from the top bit of the latched access size.
  always_comb begin
    w_load_data = bus.mem_rdata;
    case (r_size)
      2'b00: begin
        if (r_sign) w_load_data = DATA_W'($signed(bus.mem_rdata[7:0]));
        else        w_load_data = DATA_W'(bus.mem_rdata[7:0]);
      end
      2'b01: begin
        if (r_sign) w_load_data = DATA_W'($signed(bus.mem_rdata[15:0]));
        else        w_load_data = DATA_W'(bus.mem_rdata[15:0]);
      end
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  assign w_expired = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and next MAR/MDR/latched request fields.
  always_comb begin
    w_state_nxt = r_state;
    w_mar_nxt   = r_mar;
    w_mdr_nxt   = r_mdr;
    w_rw_nxt    = r_rw;
    w_size_nxt  = r_size;
    w_sign_nxt  = r_sign;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mar_nxt = bus.addr_in[ADDR_W-1:0];
          if (w_illegal) begin
            w_state_nxt = S_ERR;
          end else begin
            w_rw_nxt    = bus.rw;
            w_size_nxt  = bus.size;
            w_sign_nxt  = bus.sign;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REQ;
            if (!bus.rw) w_mdr_nxt = w_store_data;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_moc) begin
          if (r_rw) w_mdr_nxt = w_load_data;
          w_state_nxt = S_DONE;
        end else if (w_expired) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_mar  <= '0;
      r_mdr  <= '0;
      r_rw   <= 1'b0;
      r_size <= 2'b00;
      r_sign <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_mar  <= w_mar_nxt;
      r_mdr  <= w_mdr_nxt;
      r_rw   <= w_rw_nxt;
      r_size <= w_size_nxt;
      r_sign <= w_sign_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.mar_out   = r_mar;
  assign bus.mdr_out   = r_mdr;
  assign bus.mem_wdata = r_mdr;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_size  = r_size;
  assign bus.mem_en    = (r_state == S_REQ);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_ERR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transfer-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_access_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 15;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_legal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] f_mask(input logic [31:0] d, input logic [1:0] sz);
    longint unsigned v;
    v = longint'(d) % (64'd1 << (8 << sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz, input bit sgn);
    longint unsigned n;
    longint unsigned v;
    n = 64'd8 << sz;
    v = longint'(d) % (64'd1 << n);
    if (sgn && v >= (64'd1 << (n - 1))) v = v + (64'd1 << 32) - (64'd1 << n);
    return v[31:0];
  endfunction

  // Transfer-level model: what the unit must show after each edge.
  int          m_phase;
  int          m_en_cyc;
  logic [7:0]  m_mar;
  logic [31:0] m_mdr;
  bit          m_rw;
  logic [1:0]  m_size;
  bit          m_sign;

  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      m_phase <= P_IDLE; m_en_cyc <= 0; m_mar <= '0; m_mdr <= '0;
      m_rw <= 1'b0; m_size <= 2'b00; m_sign <= 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (bus.start) begin
          m_mar <= 8'(bus.addr_in % 256);
          if (!f_legal(bus.size, bus.addr_in)) m_phase <= P_ERR;
          else begin
            m_rw <= bus.rw; m_size <= bus.size; m_sign <= bus.sign;
            m_en_cyc <= 1;
            if (!bus.rw) m_mdr <= f_mask(bus.wdata_in, bus.size);
            m_phase <= P_WAIT;
          end
        end
        P_WAIT: begin
          if (bus.mem_moc) begin
            if (m_rw) m_mdr <= f_extend(bus.mem_rdata, m_size, m_sign);
            m_phase <= P_DONE;
          end else if (TO != 0 && m_en_cyc == int'(TO)) m_phase <= P_ERR;
          else m_en_cyc <= m_en_cyc + 1;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (CLR === 1'b1) begin
      chk("mar_out",   32'(bus.mar_out), 32'(m_mar));
      chk("mdr_out",   bus.mdr_out, m_mdr);
      chk("mem_wdata", bus.mem_wdata, m_mdr);
      chk("mem_rw",    32'(bus.mem_rw), 32'(m_rw));
      chk("mem_size",  32'(bus.mem_size), 32'(m_size));
      chk("mem_en",    32'(bus.mem_en), 32'(m_phase == P_WAIT));
      chk("busy",      32'(bus.busy), 32'(m_phase != P_IDLE));
      chk("done",      32'(bus.done), 32'(m_phase == P_DONE));
      chk("err",       32'(bus.err), 32'(m_phase == P_ERR));
    end
  end

  // RAM model: asserts MOC during the moc_at-th cycle of mem_en (0 = never).
  int moc_at    = 0;
  int en_seen   = 0;
  bit force_moc = 1'b0;

  always @(negedge CLK) begin
    if (bus.mem_en) en_seen = en_seen + 1;
    else            en_seen = 0;
    bus.mem_moc = force_moc | (bus.mem_en && moc_at != 0 && en_seen == moc_at);
  end

  task automatic do_xfer(input bit rw, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int moc_cycle, input bit spam,
                         output int en_cyc, output int dn, output int er, output int first_err);
    int n;
    @(negedge CLK);
    bus.rw = rw; bus.size = sz; bus.sign = sgn; bus.addr_in = addr;
    bus.wdata_in = wdata; bus.mem_rdata = rdata; moc_at = moc_cycle;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    first_err = int'(bus.err);
    en_cyc = 0; dn = 0; er = 0; n = 0;
    while (bus.busy && n < 100) begin
      en_cyc += int'(bus.mem_en); dn += int'(bus.done); er += int'(bus.err);
      bus.start = spam;
      @(negedge CLK);
      n++;
    end
    bus.start = 1'b0;
    chk("xfer_finished", 32'(n < 100), 32'd1);
  endtask

  int en_c, dn_c, er_c, fe_c;

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.sign = 1'b0;
    bus.addr_in = '0; bus.wdata_in = '0; bus.mem_rdata = '0; bus.mem_moc = 1'b0;

    // Reset values.
    #1;
    chk("rst_mar", 32'(bus.mar_out), 32'h0);
    chk("rst_mdr", bus.mdr_out, 32'h0);
    chk("rst_en",  32'(bus.mem_en), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done_err", 32'({bus.done, bus.err}), 32'h0);
    repeat (2) @(negedge CLK);
    CLR = 1'b1;

    // Word load, MOC after two wait cycles.
    do_xfer(1'b1, 2'b10, 1'b0, 32'h24, 32'h0, 32'hDEADBEEF, 3, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("wl_mdr", bus.mdr_out, 32'hDEADBEEF);
    chk("wl_mar", 32'(bus.mar_out), 32'h24);
    chk("wl_en_cycles", 32'(en_c), 32'd3);
    chk("wl_done_cycles", 32'(dn_c), 32'd1);
    chk("wl_err", 32'(er_c), 32'd0);

    // Byte loads with and without sign extension, halfword sign extension.
    do_xfer(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("lb_sext", bus.mdr_out, 32'hFFFFFF80);
    chk("lb_en_cycles", 32'(en_c), 32'd1);
    do_xfer(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("lb_zext", bus.mdr_out, 32'h00000080);
    do_xfer(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000F00F, 2, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("lh_sext", bus.mdr_out, 32'hFFFFF00F);

    // Stores: sign input must not alter the data; upper address bits dropped.
    do_xfer(1'b0, 2'b00, 1'b1, 32'h31, 32'h12345678, 32'hFFFFFFFF, 1, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("sb_wdata", bus.mem_wdata, 32'h00000078);
    chk("sb_rw", 32'(bus.mem_rw), 32'd0);
    chk("sb_size", 32'(bus.mem_size), 32'd0);
    do_xfer(1'b0, 2'b01, 1'b1, 32'hABCD0052, 32'h1234D678, 32'h0, 2, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("sh_wdata", bus.mem_wdata, 32'h0000D678);
    chk("sh_mar", 32'(bus.mar_out), 32'h52);

    // Misaligned word and illegal size: immediate error, no memory cycle.
    do_xfer(1'b1, 2'b10, 1'b0, 32'h26, 32'h0, 32'h11111111, 1, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("mis_err_first", 32'(fe_c), 32'd1);
    chk("mis_err_cycles", 32'(er_c), 32'd1);
    chk("mis_en_cycles", 32'(en_c), 32'd0);
    chk("mis_mar", 32'(bus.mar_out), 32'h26);
    chk("mis_mdr_kept", bus.mdr_out, 32'h0000D678);
    do_xfer(1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 32'h11111111, 1, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("sz11_err_first", 32'(fe_c), 32'd1);
    chk("sz11_en_cycles", 32'(en_c), 32'd0);
    chk("sz11_mar", 32'(bus.mar_out), 32'h40);

    // Timeout with MOC never arriving; start pulses while busy are ignored.
    do_xfer(1'b1, 2'b10, 1'b0, 32'h08, 32'h0, 32'h22222222, 0, 1'b1, en_c, dn_c, er_c, fe_c);
    chk("to_en_cycles", 32'(en_c), 32'd15);
    chk("to_err_cycles", 32'(er_c), 32'd1);
    chk("to_done", 32'(dn_c), 32'd0);
    chk("to_mdr_kept", bus.mdr_out, 32'h0000D678);
    chk("to_idle_after", 32'(bus.busy), 32'd0);

    // MOC on the expiry edge wins.
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hCAFEF00D, 15, 1'b0, en_c, dn_c, er_c, fe_c);
    chk("late_en_cycles", 32'(en_c), 32'd15);
    chk("late_done", 32'(dn_c), 32'd1);
    chk("late_err", 32'(er_c), 32'd0);
    chk("late_mdr", bus.mdr_out, 32'hCAFEF00D);

    // MOC while idle is ignored.
    @(negedge CLK); force_moc = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_moc_busy", 32'(bus.busy), 32'd0);
    chk("idle_moc_mdr", bus.mdr_out, 32'hCAFEF00D);
    force_moc = 1'b0;

    // Asynchronous reset in the middle of a load.
    @(negedge CLK);
    bus.rw = 1'b1; bus.size = 2'b10; bus.addr_in = 32'h10; moc_at = 0; bus.start = 1'b1;
    @(negedge CLK); bus.start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_en_before", 32'(bus.mem_en), 32'd1);
    #2 CLR = 1'b0;
    #1;
    chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_mar", 32'(bus.mar_out), 32'h0);
    chk("mid_rst_mdr", bus.mdr_out, 32'h0);
    @(negedge CLK); CLR = 1'b1;
    dn_c = 0; er_c = 0;
    repeat (6) begin
      @(negedge CLK);
      dn_c += int'(bus.done); er_c += int'(bus.err);
    end
    chk("post_rst_done", 32'(dn_c), 32'd0);
    chk("post_rst_err", 32'(er_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access front end for the multicycle datapath. It combines the address register (MAR) and data register (MDR) with a memory handshake FSM. It runs byte/halfword/word loads and stores against a memory that signals completion with MOC, and returns zero- or sign-extended load data. It adds alignment checking and a completion timeout. It sits between the control unit (start/done) and the RAM model.

## Interface
- DATA_W, 32 — datapath/MDR width; must be ≥16 and a multiple of 8.
- ADDR_W, 8 — MAR / memory address width.
- TIMEOUT, 15 — maximum cycles mem_en may stay high awaiting MOC; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- start  in  1  request a transfer; sampled only in IDLE.
- rw  in  1  1 = load, 0 = store.
- size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and raises err.
- sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr_in  in  DATA_W  byte address; only [ADDR_W-1:0] is kept.
- wdata_in  in  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, right-aligned by memory.
- mem_moc  in  1  memory operation complete.
- mar_out  out  ADDR_W  latched address; equals mem_addr.
- mdr_out  out  DATA_W  latched store data, or extended load data.
- mem_en  out  1  memory request.
- mem_rw  out  1  latched rw.
- mem_size  out  2  latched size.
- mem_wdata  out  DATA_W  equals mdr_out.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on misalignment, illegal size, or timeout.

## Operation
- States: IDLE, REQ, DONE, ERR, encoded as 2-bit state.
- IDLE, start=1 with a legal, aligned request:
  - MAR ← addr_in[ADDR_W-1:0]; latch rw and size.
  - On a store, MDR ← wdata_in with bits above the access size cleared.
  - Clear the timeout counter; go to REQ.
- IDLE, start=1 with an illegal request goes to ERR. MAR still latches the address; MDR is unchanged; no memory cycle occurs.
  - Halfword is misaligned if addr_in[0]=1.
  - Word is misaligned if addr_in[1:0]≠0.
  - size=11 is illegal.
- IDLE, start=0: hold.
- REQ: mem_en=1.
  - mem_moc=1 at an edge: on a load, MDR ← mem_rdata extended from bit 7, bit 15, or full width per size/sign; go to DONE.
  - mem_moc=0 and TIMEOUT≠0 and counter=TIMEOUT-1: go to ERR; MDR unchanged.
  - Otherwise the counter increments.
- DONE: done=1; go to IDLE.
- ERR: err=1; go to IDLE.
- start outside IDLE is ignored, not queued.
- Store data is not altered by the sign input.
- MAR and MDR hold their values between transfers.

## Timing
- Reset (CLR=0, asynchronous):
  - state=IDLE; mar_out=0, mdr_out=0, mem_en=0, mem_rw=0, mem_size=0, busy=0, done=0, err=0, counter=0.
  - Outputs clear immediately, without waiting for a clock edge.
  - CLR during REQ drops mem_en in the same cycle, and no done/err is produced for the aborted transfer.
- mem_en, busy, done and err are decoded from the registered state only.
- Start latency: start sampled at edge 0 → mem_en high from edge 0.
- Completion: mem_moc sampled high at edge k → done high from edge k to edge k+1.
  - Best case k=1: 3 cycles from start to the next accepted start.
- Timeout: mem_en is high for exactly TIMEOUT cycles, then err pulses for 1 cycle.
- mem_moc arriving on the same edge as the timeout expiry wins: the transfer completes and err stays low.
- mem_moc outside REQ is ignored.
- ADDR_W > DATA_W is illegal; flag it with an elaboration-time check.

## Test plan
- Reset: CLR low mid-REQ (addr 0x10, load) → mem_en and busy drop asynchronously, mar_out=0, and no done pulse follows CLR release.
- Word load: addr 0x24, mem_rdata=0xDEADBEEF with MOC after 2 wait cycles → mdr_out=0xDEADBEEF, done high exactly 1 cycle, mem_en high 3 cycles.
- Byte load, sign=1: mem_rdata=0x00000080 → mdr_out=0xFFFFFF80. Same with sign=0 → 0x00000080. Halfword, sign=1, data 0x0000F00F → 0xFFFFF00F.
- Byte store: wdata_in=0x12345678 → mem_wdata=0x00000078, mem_rw=0, mem_size=00.
- Misaligned word at addr 0x26 → err pulse the cycle after start, mem_en never asserts, mar_out=0x26. Same for size=11.
- Timeout: TIMEOUT=15 with MOC never asserted → mem_en high 15 cycles, then err pulse. MOC on the 15th edge → done instead, err stays 0. Start pulses during busy are ignored.
